contador_mod_param: RTL and testbench

- Parametrised multi-digit modulo counter that counts up or down, e.g. a BCD countdown timer.
- Each digit counts modulo BASE. Digits cascade by carry/borrow from digit 0 (least significant) upward.
- Adds over the single-digit fixed counter:
  - direction control
  - count enable
  - synchronous parallel load
  - selectable wrap/saturate mode
  - terminal-count pulse and zero flag, used to drive timeouts and display logic.

---
 rtl/contador_mod_param.sv | 101 ++++++++++
 tb/tb_contador_mod_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/contador_mod_param.sv
// Multi-digit modulo-BASE up/down counter with enable, parallel load,
// wrap or saturate at the all-zero / all-max boundary, and a terminal-count pulse.
module contador_mod_param #(
    parameter int unsigned               DIGITS    = 2,
    parameter int unsigned               DIG_W     = 4,
    parameter int unsigned               BASE      = 10,
    parameter logic [DIGITS*DIG_W-1:0]   RESET_VAL = 5,
    parameter bit                        WRAP_MODE = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGITS*DIG_W-1:0]   load_val,
    output logic [DIGITS*DIG_W-1:0]   count,
    output logic                      tc,
    output logic                      zero
);

    localparam int unsigned      W        = DIGITS * DIG_W;
    localparam logic [DIG_W-1:0] DIG_MAX  = DIG_W'(BASE - 1);
    localparam logic [DIG_W:0]   BASE_EXT = (DIG_W + 1)'(BASE);

    logic [W-1:0]     count_q, count_d;
    logic             tc_q, tc_d;
    logic [W-1:0]     load_clamped;
    logic [W-1:0]     stepped;
    logic             all_max, all_zero, boundary;
    logic             ripple;
    logic [DIG_W-1:0] dig;

    always_comb begin
        load_clamped = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ({1'b0, load_val[i*DIG_W +: DIG_W]} >= BASE_EXT) begin
                load_clamped[i*DIG_W +: DIG_W] = DIG_MAX;
            end else begin
                load_clamped[i*DIG_W +: DIG_W] = load_val[i*DIG_W +: DIG_W];
            end
        end
    end

    // Carry/borrow ripples from digit 0; a full ripple naturally produces the wrap value.
    always_comb begin
        stepped  = count_q;
        ripple   = 1'b1;
        all_max  = 1'b1;
        all_zero = 1'b1;
        dig      = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = count_q[i*DIG_W +: DIG_W];
            if (dig != DIG_MAX) all_max = 1'b0;
            if (dig != '0)      all_zero = 1'b0;
            if (ripple) begin
                if (up) begin
                    if (dig == DIG_MAX) begin
                        stepped[i*DIG_W +: DIG_W] = '0;
                    end else begin
                        stepped[i*DIG_W +: DIG_W] = dig + 1'b1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (dig == '0) begin
                        stepped[i*DIG_W +: DIG_W] = DIG_MAX;
                    end else begin
                        stepped[i*DIG_W +: DIG_W] = dig - 1'b1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        boundary = up ? all_max : all_zero;
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            tc_d    = boundary;
            count_d = (boundary && !WRAP_MODE) ? count_q : stepped;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_contador_mod_param.sv
// Randomised bench: a wrap and a saturate instance checked every cycle against
// an integer-valued reference model, plus literal checks of the directed scenarios.
module tb_contador_mod_param;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned BASE   = 10;
    localparam int unsigned W      = DIGITS * DIG_W;
    localparam int unsigned N      = BASE ** DIGITS;
    localparam logic [W-1:0] RV    = 8'h05;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] count_w, count_s;
    logic         tc_w, tc_s, zero_w, zero_s;

    int n_total = 0;
    int n_pass  = 0;

    // reference model: counter value as a plain integer 0..N-1
    int unsigned m_val_w, m_val_s;
    bit          m_tc_w, m_tc_s;

    always #5 clk = ~clk;

    contador_mod_param #(.DIGITS(DIGITS), .DIG_W(DIG_W), .BASE(BASE),
                         .RESET_VAL(RV), .WRAP_MODE(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .zero(zero_w));

    contador_mod_param #(.DIGITS(DIGITS), .DIG_W(DIG_W), .BASE(BASE),
                         .RESET_VAL(RV), .WRAP_MODE(1'b0)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_s), .tc(tc_s), .zero(zero_s));

    function automatic int unsigned to_value(input logic [W-1:0] p);
        int unsigned v = 0;
        int unsigned d;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(p[i*DIG_W +: DIG_W]);
            if (d >= BASE) d = BASE - 1;
            v = v * BASE + d;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] to_packed(input int unsigned v);
        logic [W-1:0] p = '0;
        int unsigned  r = v;
        for (int i = 0; i < DIGITS; i++) begin
            p[i*DIG_W +: DIG_W] = DIG_W'(r % BASE);
            r = r / BASE;
        end
        return p;
    endfunction

    function automatic int unsigned next_val(input int unsigned v, input bit wrap);
        if (load) return to_value(load_val);
        if (!en) return v;
        if (up) begin
            if (v == N - 1) return wrap ? 0 : v;
            return v + 1;
        end
        if (v == 0) return wrap ? N - 1 : 0;
        return v - 1;
    endfunction

    function automatic bit next_tc(input int unsigned v);
        return !load && en && (up ? (v == N - 1) : (v == 0));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_val_w <= to_value(RV);
            m_val_s <= to_value(RV);
            m_tc_w  <= 1'b0;
            m_tc_s  <= 1'b0;
        end else begin
            m_val_w <= next_val(m_val_w, 1'b1);
            m_val_s <= next_val(m_val_s, 1'b0);
            m_tc_w  <= next_tc(m_val_w);
            m_tc_s  <= next_tc(m_val_s);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("wrap.count", 32'(count_w), 32'(to_packed(m_val_w)));
            chk("wrap.tc",    32'(tc_w),    32'(m_tc_w));
            chk("wrap.zero",  32'(zero_w),  32'(m_val_w == 0));
            chk("sat.count",  32'(count_s), 32'(to_packed(m_val_s)));
            chk("sat.tc",     32'(tc_s),    32'(m_tc_s));
            chk("sat.zero",   32'(zero_s),  32'(m_val_s == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
    endtask

    logic [W-1:0] exp_seq [6];

    initial begin
        exp_seq[0] = 8'h04; exp_seq[1] = 8'h03; exp_seq[2] = 8'h02;
        exp_seq[3] = 8'h01; exp_seq[4] = 8'h00; exp_seq[5] = 8'h99;

        #1 reset = 1'b0;
        #1;
        chk("rst.count", 32'(count_w), 32'h05);
        chk("rst.tc",    32'(tc_w),    32'h0);
        chk("rst.zero",  32'(zero_w),  32'h0);
        cmp_on = 1'b1;

        // scenario 1 and saturate scenario 5
        en = 1'b1; up = 1'b0; reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s1.count", 32'(count_w), 32'(exp_seq[i]));
            chk("s1.tc",    32'(tc_w),    32'(i == 5));
            chk("s1.zero",  32'(zero_w),  32'(i == 4));
        end
        chk("s5.count", 32'(count_s), 32'h00);
        chk("s5.tc",    32'(tc_s),    32'h1);
        tick();
        chk("s1.after", 32'(count_w), 32'h98);
        chk("s1.tcoff", 32'(tc_w),    32'h0);
        chk("s5.hold",  32'(count_s), 32'h00);
        chk("s5.tc2",   32'(tc_s),    32'h1);
        tick();
        chk("s5.tc3",   32'(tc_s),    32'h1);
        up = 1'b1;
        tick();
        chk("s5.up",    32'(count_s), 32'h01);
        chk("s5.uptc",  32'(tc_s),    32'h0);

        // scenario 2
        up = 1'b0;
        do_load(8'h40);
        chk("s2.load", 32'(count_w), 32'h40);
        tick();
        chk("s2.39",   32'(count_w), 32'h39);
        chk("s2.tc",   32'(tc_w),    32'h0);
        do_load(8'h10);
        tick();
        chk("s2.09",   32'(count_w), 32'h09);
        chk("s2.tc2",  32'(tc_w),    32'h0);

        // scenario 3
        do_load(8'h98);
        up = 1'b1;
        tick();
        chk("s3.99",   32'(count_w), 32'h99);
        chk("s3.tc0",  32'(tc_w),    32'h0);
        tick();
        chk("s3.00",   32'(count_w), 32'h00);
        chk("s3.tc1",  32'(tc_w),    32'h1);
        do_load(8'h09);
        tick();
        chk("s3.10",   32'(count_w), 32'h10);

        // scenario 4: load beats en, digits clamp
        up = 1'b0;
        do_load(8'h37);
        chk("s4.37",   32'(count_w), 32'h37);
        do_load(8'hA5);
        chk("s4.95",   32'(count_w), 32'h95);
        chk("s4.tc",   32'(tc_w),    32'h0);
        do_load(8'hFF);
        chk("s4.99",   32'(count_w), 32'h99);

        // scenario 6: asynchronous reset mid-cycle
        do_load(8'h62);
        en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("s6.count", 32'(count_w), 32'h05);
        chk("s6.tc",    32'(tc_w),    32'h0);
        tick();
        chk("s6.held",  32'(count_w), 32'h05);
        reset = 1'b1; en = 1'b1; up = 1'b0;
        tick();
        chk("s6.04",    32'(count_w), 32'h04);

        // randomised phase
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (!reset) reset = 1'b1;
            else if (r == 99) reset = 1'b0;
            load = (r < 8);
            en   = ($urandom_range(0, 3) != 0);
            up   = (i % 300 < 150) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 4))
                0: load_val = 8'h99;
                1: load_val = 8'h00;
                2: load_val = 8'h98;
                3: load_val = 8'h01;
                default: load_val = W'($urandom);
            endcase
            tick();
        end

        reset = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        @(negedge clk);
        #1;
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
